count_stream_checker: RTL and testbench
=======================================

// Module: count_stream_checker
// PURPOSE
//  - Consumer-side checker for the 16-bit free-running up-counter: samples its count output and verifies +1 per valid sample.
//  - Locks after a run of correct increments, flags/counts sequence breaks, reports wrap events.
//  - Sits beside the counter in the top level; results go to a debug bus or LEDs.
// PARAMETERS
//  - WIDTH    16  width of checked count (compare is modulo 2^WIDTH)
//  - LOCK_N   4   consecutive correct increments required to assert locked (>=1)
//  - ERR_W    8   width of saturating error counter
// PORTS
//  - clk          in   1      rising-edge clock, same domain as counter
//  - reset        in   1      synchronous, active-high
//  - count_in     in   WIDTH  count value under check
//  - count_valid  in   1      count_in is sampled only when 1
//  - err_clr      in   1      synchronous clear of err_count
//  - locked       out  1      sequence tracked and correct
//  - err_pulse    out  1      one-cycle pulse per sequence break while locked
//  - wrap_pulse   out  1      one-cycle pulse on accepted all-ones -> 0 step
//  - err_count    out  ERR_W  saturating count of sequence breaks
//  - last_good    out  WIDTH  last sample accepted as correct
// BEHAVIOUR
//  - All outputs registered; visible 1 cycle after the sampling edge. count_valid=0: state, outputs hold; pulses 0.
//  - Reset (wins over all inputs, mid-operation too): state=HUNT, match_cnt=0, prev=0; outputs all 0.
//  - "Correct" sample: count_in == prev + 1 mod 2^WIDTH (0xFFFF -> 0x0000 correct, wrap_pulse=1, any state except HUNT).
//  - FSM HUNT: first valid sample -> prev=sample, match_cnt=0, -> SYNC. No error, no last_good update.
//  - FSM SYNC: correct -> match_cnt++, last_good=sample; match_cnt reaches LOCK_N -> LOCKED, locked=1.
//      wrong -> prev=sample, match_cnt=0, stay SYNC, no error.
//  - FSM LOCKED: correct -> stay, last_good=sample.
//      wrong -> err_pulse=1, err_count+1 (sat at 2^ERR_W-1), prev=sample, match_cnt=0, -> SYNC, locked=0.
//  - prev updated with every valid sample in every state.
//  - err_clr with no error -> err_count=0; err_clr same cycle as error -> err_count=1.
//  - Saturated err_count: err_pulse still fires, count holds at max.
// CONFIGURATION
//  - COUNT_CHK_STALL_TOL_EN defined: sample == prev (counter held) is neutral in SYNC/LOCKED:
//      no error, match_cnt unchanged, no last_good update.
//  - Undefined: a repeated value is a wrong sample (error if LOCKED).
// STRUCTURE
//  - Package count_chk_pkg: chk_state_t enum {HUNT, SYNC, LOCKED}; COUNT_W=16 default constant.
//  - Sub-module sat_counter (WIDTH, inc, clr, q; clr+inc -> 1) implements err_count.
//  - Top: FSM, prev/last_good registers, comparator, wrap detect.
// TESTING
//  - Reset then valid counter 0,1,2,... -> locked=1 after sample 4 (LOCK_N=4), err_count=0, last_good tracks.
//  - Locked, inject 0x0010 after 0x000A -> err_pulse 1 cycle, err_count=1, locked=0; relocks after 4 correct from 0x0010.
//  - Locked at 0xFFFE,0xFFFF,0x0000 -> wrap_pulse once on 0x0000, no error, locked stays 1.
//  - ERR_W=2, 5 forced breaks -> err_count=3, 5 err_pulses; err_clr with break same cycle -> err_count=1.
//  - Repeat 0x0020 twice while locked -> macro undefined: err_pulse, err_count+1; defined: no error, locked stays 1.
//  - Assert reset mid-LOCKED with count_valid=1 -> next cycle all outputs 0, state HUNT; count_valid=0 gaps hold outputs.

Source files
------------

// File: rtl/count_chk_pkg.sv
// Shared types for the count stream checker: FSM state encoding and
// the default width of the checked counter.
package count_chk_pkg;

    localparam int COUNT_W = 16;

    typedef enum logic [1:0] {
        HUNT,
        SYNC,
        LOCKED
    } chk_state_t;

endpackage

// File: rtl/count_stream_checker_sat_counter.sv
// Saturating up-counter with synchronous clear (clear + increment -> 1).
// Ports: clk, reset (sync, active-high), inc, clr, q (WIDTH).
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            // An event in the clear cycle is counted, not lost.
            q_d = inc ? WIDTH'(1) : '0;
        end else if (inc && (q_q != '1)) begin
            q_d = q_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/count_stream_checker.sv
// Checks a free-running up-counter for +1 steps per valid sample, locks
// after LOCK_N correct steps, pulses/counts breaks and wraps.
// Ports: clk, reset (sync, active-high), count_in, count_valid, err_clr
//        -> locked, err_pulse, wrap_pulse, err_count, last_good.
// Option: COUNT_CHK_STALL_TOL_EN makes a repeated value neutral.
module count_stream_checker
    import count_chk_pkg::*;
#(
    parameter int WIDTH  = COUNT_W,
    parameter int LOCK_N = 4,
    parameter int ERR_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] count_in,
    input  logic             count_valid,
    input  logic             err_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic             wrap_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] last_good
);

    localparam int MW = $clog2(LOCK_N + 1);

    chk_state_t       state_q;
    logic [MW-1:0]    match_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] last_good_q;
    logic             locked_q;
    logic             err_pulse_q;
    logic             wrap_pulse_q;

    logic [WIDTH-1:0] prev_inc;
    logic             is_inc;
    logic             is_wrap;
    logic             stall_ok;
    logic             err_hit;

    assign prev_inc = prev_q + WIDTH'(1);
    assign is_inc   = (count_in == prev_inc);
    assign is_wrap  = (prev_q == '1);

`ifdef COUNT_CHK_STALL_TOL_EN
    // Counter held: neither progress nor a break.
    assign stall_ok = (count_in == prev_q);
`else
    assign stall_ok = 1'b0;
`endif

    assign err_hit = count_valid && (state_q == LOCKED)
                     && !is_inc && !stall_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= HUNT;
            match_q      <= '0;
            prev_q       <= '0;
            last_good_q  <= '0;
            locked_q     <= 1'b0;
            err_pulse_q  <= 1'b0;
            wrap_pulse_q <= 1'b0;
        end else begin
            err_pulse_q  <= 1'b0;
            wrap_pulse_q <= 1'b0;
            if (count_valid) begin
                prev_q <= count_in;
                case (state_q)
                    HUNT: begin
                        match_q <= '0;
                        state_q <= SYNC;
                    end
                    SYNC: begin
                        if (!stall_ok) begin
                            if (is_inc) begin
                                last_good_q  <= count_in;
                                wrap_pulse_q <= is_wrap;
                                match_q      <= match_q + MW'(1);
                                if (match_q == MW'(LOCK_N - 1)) begin
                                    state_q  <= LOCKED;
                                    locked_q <= 1'b1;
                                end
                            end else begin
                                match_q <= '0;
                            end
                        end
                    end
                    LOCKED: begin
                        if (!stall_ok) begin
                            if (is_inc) begin
                                last_good_q  <= count_in;
                                wrap_pulse_q <= is_wrap;
                            end else begin
                                err_pulse_q <= 1'b1;
                                match_q     <= '0;
                                state_q     <= SYNC;
                                locked_q    <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state_q  <= HUNT;
                        match_q  <= '0;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    sat_counter #(
        .WIDTH(ERR_W)
    ) u_err_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (err_hit),
        .clr  (err_clr),
        .q    (err_count)
    );

    assign locked     = locked_q;
    assign err_pulse  = err_pulse_q;
    assign wrap_pulse = wrap_pulse_q;
    assign last_good  = last_good_q;

endmodule

// File: tb/tb_count_stream_checker.sv
// Directed testbench for count_stream_checker (default ERR_W and a
// second instance with ERR_W=2 for saturation).
module tb_count_stream_checker;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] count_in = '0;
    logic        count_valid = 1'b0;
    logic        err_clr = 1'b0;

    logic        locked, err_pulse, wrap_pulse;
    logic [7:0]  err_count;
    logic [15:0] last_good;

    logic        locked2, err_pulse2, wrap_pulse2;
    logic [1:0]  err_count2;
    logic [15:0] last_good2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    count_stream_checker dut (
        .clk        (clk),
        .reset      (reset),
        .count_in   (count_in),
        .count_valid(count_valid),
        .err_clr    (err_clr),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .wrap_pulse (wrap_pulse),
        .err_count  (err_count),
        .last_good  (last_good)
    );

    count_stream_checker #(.ERR_W(2)) dut2 (
        .clk        (clk),
        .reset      (reset),
        .count_in   (count_in),
        .count_valid(count_valid),
        .err_clr    (err_clr),
        .locked     (locked2),
        .err_pulse  (err_pulse2),
        .wrap_pulse (wrap_pulse2),
        .err_count  (err_count2),
        .last_good  (last_good2)
    );

    task automatic feed(input logic [15:0] v, input logic clr);
        count_valid = 1'b1;
        count_in    = v;
        err_clr     = clr;
        @(posedge clk);
        #1;
        count_valid = 1'b0;
        err_clr     = 1'b0;
    endtask

    task automatic idle();
        count_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        count_valid = 1'b0;
        err_clr     = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        count_valid = 1'b1;
        count_in    = 16'h1234;
        @(posedge clk);
        #1;
        checks++;
        if (locked !== 1'b0) begin failures++; $display("FAIL rst_locked got=%0h exp=0", locked); end
        checks++;
        if (err_pulse !== 1'b0 || wrap_pulse !== 1'b0) begin
            failures++; $display("FAIL rst_pulses got=%0b%0b exp=00", err_pulse, wrap_pulse);
        end
        checks++;
        if (err_count !== 8'h0) begin failures++; $display("FAIL rst_errcnt got=%0h exp=0", err_count); end
        checks++;
        if (last_good !== 16'h0) begin failures++; $display("FAIL rst_lastgood got=%0h exp=0", last_good); end
        reset       = 1'b0;
        count_valid = 1'b0;
    endtask

    task automatic test_lock();
        do_reset();
        feed(16'h0, 1'b0);
        feed(16'h1, 1'b0);
        feed(16'h2, 1'b0);
        feed(16'h3, 1'b0);
        checks++;
        if (locked !== 1'b0) begin failures++; $display("FAIL lock_early got=%0h exp=0", locked); end
        checks++;
        if (last_good !== 16'h3) begin failures++; $display("FAIL lock_lg3 got=%0h exp=3", last_good); end
        feed(16'h4, 1'b0);
        checks++;
        if (locked !== 1'b1) begin failures++; $display("FAIL lock_at4 got=%0h exp=1", locked); end
        checks++;
        if (err_count !== 8'h0) begin failures++; $display("FAIL lock_errcnt got=%0h exp=0", err_count); end
        for (int v = 5; v <= 10; v++) feed(16'(v), 1'b0);
        checks++;
        if (last_good !== 16'hA || locked !== 1'b1) begin
            failures++; $display("FAIL lock_track lg=%0h lk=%0b exp lg=a lk=1", last_good, locked);
        end
    endtask

    task automatic test_break();
        feed(16'h10, 1'b0);
        checks++;
        if (err_pulse !== 1'b1) begin failures++; $display("FAIL brk_pulse got=%0h exp=1", err_pulse); end
        checks++;
        if (err_count !== 8'h1) begin failures++; $display("FAIL brk_errcnt got=%0h exp=1", err_count); end
        checks++;
        if (locked !== 1'b0) begin failures++; $display("FAIL brk_unlock got=%0h exp=0", locked); end
        checks++;
        if (last_good !== 16'hA) begin failures++; $display("FAIL brk_lg got=%0h exp=a", last_good); end
        feed(16'h11, 1'b0);
        checks++;
        if (err_pulse !== 1'b0) begin failures++; $display("FAIL brk_pulse1cyc got=%0h exp=0", err_pulse); end
        checks++;
        if (last_good !== 16'h11) begin failures++; $display("FAIL brk_lg11 got=%0h exp=11", last_good); end
        feed(16'h12, 1'b0);
        feed(16'h13, 1'b0);
        checks++;
        if (locked !== 1'b0) begin failures++; $display("FAIL brk_relock_early got=%0h exp=0", locked); end
        feed(16'h14, 1'b0);
        checks++;
        if (locked !== 1'b1) begin failures++; $display("FAIL brk_relock got=%0h exp=1", locked); end
        checks++;
        if (err_count !== 8'h1) begin failures++; $display("FAIL brk_errhold got=%0h exp=1", err_count); end
    endtask

    task automatic test_wrap();
        do_reset();
        feed(16'hFFF9, 1'b0);
        feed(16'hFFFA, 1'b0);
        feed(16'hFFFB, 1'b0);
        feed(16'hFFFC, 1'b0);
        feed(16'hFFFD, 1'b0);
        feed(16'hFFFE, 1'b0);
        feed(16'hFFFF, 1'b0);
        checks++;
        if (wrap_pulse !== 1'b0 || locked !== 1'b1) begin
            failures++; $display("FAIL wrap_pre wr=%0b lk=%0b exp wr=0 lk=1", wrap_pulse, locked);
        end
        feed(16'h0000, 1'b0);
        checks++;
        if (wrap_pulse !== 1'b1) begin failures++; $display("FAIL wrap_pulse got=%0h exp=1", wrap_pulse); end
        checks++;
        if (err_pulse !== 1'b0 || err_count !== 8'h0) begin
            failures++; $display("FAIL wrap_noerr ep=%0b ec=%0h exp ep=0 ec=0", err_pulse, err_count);
        end
        checks++;
        if (locked !== 1'b1 || last_good !== 16'h0) begin
            failures++; $display("FAIL wrap_lock lk=%0b lg=%0h exp lk=1 lg=0", locked, last_good);
        end
        feed(16'h0001, 1'b0);
        checks++;
        if (wrap_pulse !== 1'b0) begin failures++; $display("FAIL wrap_once got=%0h exp=0", wrap_pulse); end
    endtask

    task automatic test_gap();
        idle();
        idle();
        idle();
        checks++;
        if (locked !== 1'b1 || last_good !== 16'h1) begin
            failures++; $display("FAIL gap_hold lk=%0b lg=%0h exp lk=1 lg=1", locked, last_good);
        end
        feed(16'h0002, 1'b0);
        checks++;
        if (last_good !== 16'h2 || locked !== 1'b1 || err_pulse !== 1'b0) begin
            failures++; $display("FAIL gap_resume lg=%0h lk=%0b ep=%0b exp lg=2 lk=1 ep=0", last_good, locked, err_pulse);
        end
        feed(16'h0050, 1'b0);
        idle();
        checks++;
        if (err_pulse !== 1'b0 || err_count !== 8'h1) begin
            failures++; $display("FAIL gap_pulse0 ep=%0b ec=%0h exp ep=0 ec=1", err_pulse, err_count);
        end
    endtask

    task automatic test_saturation();
        logic [15:0] base;
        logic [1:0]  exp2;
        do_reset();
        feed(16'h0, 1'b0);
        base = 16'h0;
        for (int k = 0; k < 5; k++) begin
            for (int j = 1; j <= 4; j++) feed(base + 16'(j), 1'b0);
            base = 16'((k + 1) * 16'h100);
            feed(base, 1'b0);
            exp2 = (k + 1 >= 3) ? 2'd3 : 2'(k + 1);
            checks++;
            if (err_pulse2 !== 1'b1 || err_pulse !== 1'b1) begin
                failures++; $display("FAIL sat_pulse k=%0d got=%0b%0b exp=11", k, err_pulse, err_pulse2);
            end
            checks++;
            if (err_count !== 8'(k + 1)) begin
                failures++; $display("FAIL sat_cnt8 k=%0d got=%0h exp=%0h", k, err_count, k + 1);
            end
            checks++;
            if (err_count2 !== exp2) begin
                failures++; $display("FAIL sat_cnt2 k=%0d got=%0h exp=%0h", k, err_count2, exp2);
            end
        end
    endtask

    task automatic test_err_clr();
        for (int j = 1; j <= 4; j++) feed(16'h500 + 16'(j), 1'b0);
        feed(16'h600, 1'b1);
        checks++;
        if (err_count !== 8'h1 || err_count2 !== 2'h1) begin
            failures++; $display("FAIL clr_with_err got=%0h/%0h exp=1/1", err_count, err_count2);
        end
        checks++;
        if (err_pulse !== 1'b1) begin failures++; $display("FAIL clr_pulse got=%0h exp=1", err_pulse); end
        feed(16'h601, 1'b1);
        checks++;
        if (err_count !== 8'h0 || err_count2 !== 2'h0) begin
            failures++; $display("FAIL clr_plain got=%0h/%0h exp=0/0", err_count, err_count2);
        end
    endtask

    task automatic test_repeat();
        do_reset();
        feed(16'h1C, 1'b0);
        feed(16'h1D, 1'b0);
        feed(16'h1E, 1'b0);
        feed(16'h1F, 1'b0);
        feed(16'h20, 1'b0);
        feed(16'h20, 1'b0);
`ifdef COUNT_CHK_STALL_TOL_EN
        checks++;
        if (err_pulse !== 1'b0 || err_count !== 8'h0) begin
            failures++; $display("FAIL rep_tol ep=%0b ec=%0h exp ep=0 ec=0", err_pulse, err_count);
        end
        checks++;
        if (locked !== 1'b1 || last_good !== 16'h20) begin
            failures++; $display("FAIL rep_tol_lock lk=%0b lg=%0h exp lk=1 lg=20", locked, last_good);
        end
        feed(16'h21, 1'b0);
        checks++;
        if (locked !== 1'b1 || last_good !== 16'h21) begin
            failures++; $display("FAIL rep_tol_next lk=%0b lg=%0h exp lk=1 lg=21", locked, last_good);
        end
`else
        checks++;
        if (err_pulse !== 1'b1 || err_count !== 8'h1) begin
            failures++; $display("FAIL rep_err ep=%0b ec=%0h exp ep=1 ec=1", err_pulse, err_count);
        end
        checks++;
        if (locked !== 1'b0 || last_good !== 16'h20) begin
            failures++; $display("FAIL rep_unlock lk=%0b lg=%0h exp lk=0 lg=20", locked, last_good);
        end
        feed(16'h21, 1'b0);
        checks++;
        if (locked !== 1'b0 || last_good !== 16'h21) begin
            failures++; $display("FAIL rep_next lk=%0b lg=%0h exp lk=0 lg=21", locked, last_good);
        end
`endif
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int v = 0; v <= 4; v++) feed(16'(v), 1'b0);
        feed(16'h9, 1'b0);
        for (int v = 10; v <= 13; v++) feed(16'(v), 1'b0);
        checks++;
        if (locked !== 1'b1 || err_count !== 8'h1) begin
            failures++; $display("FAIL mrst_pre lk=%0b ec=%0h exp lk=1 ec=1", locked, err_count);
        end
        reset       = 1'b1;
        count_valid = 1'b1;
        count_in    = 16'hE;
        @(posedge clk);
        #1;
        reset       = 1'b0;
        count_valid = 1'b0;
        checks++;
        if (locked !== 1'b0 || err_count !== 8'h0 || last_good !== 16'h0) begin
            failures++; $display("FAIL mrst_out lk=%0b ec=%0h lg=%0h exp 0 0 0", locked, err_count, last_good);
        end
        checks++;
        if (err_pulse !== 1'b0 || wrap_pulse !== 1'b0 || err_count2 !== 2'h0) begin
            failures++; $display("FAIL mrst_pulses ep=%0b wp=%0b ec2=%0h exp 0 0 0", err_pulse, wrap_pulse, err_count2);
        end
        feed(16'h100, 1'b0);
        checks++;
        if (locked !== 1'b0 || last_good !== 16'h0 || err_pulse !== 1'b0) begin
            failures++; $display("FAIL mrst_hunt lk=%0b lg=%0h ep=%0b exp 0 0 0", locked, last_good, err_pulse);
        end
        feed(16'h101, 1'b0);
        checks++;
        if (last_good !== 16'h101) begin failures++; $display("FAIL mrst_sync got=%0h exp=101", last_good); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_break();
        test_wrap();
        test_gap();
        test_saturation();
        test_err_clr();
        test_repeat();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
